// File: rtl/inst_memory_responder.sv
// Instruction-memory responder for I-cache refills: 64 x 128-bit blocks, fixed-latency
// block reads, plus a 32-bit word load port usable only while idle.
module inst_memory_responder #(
    parameter int READ_LATENCY = 4
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         inst_mem_read_i,
    input  logic [5:0]   inst_mem_address_i,
    output logic [127:0] inst_mem_data_o,
    output logic         inst_mem_busywait_o,
    input  logic         load_en_i,
    input  logic [7:0]   load_addr_i,
    input  logic [31:0]  load_data_i,
    output logic         load_ready_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] LAT_M1 = 4'(READ_LATENCY - 1);

    state_t       state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [5:0]   addr_q, addr_d;
    logic [127:0] data_q, data_d;
    logic [127:0] mem_q [64];
    logic [5:0]   rd_blk;
    logic [6:0]   lane_base;

    // Latency 1 reads straight from the request address on the accept edge.
    assign rd_blk    = (state_q == IDLE) ? inst_mem_address_i : addr_q;
    assign lane_base = {~load_addr_i[1:0], 5'b0_0000};

    assign inst_mem_data_o     = data_q;
    assign inst_mem_busywait_o = inst_mem_read_i & (state_q != DONE);
    assign load_ready_o        = (state_q == IDLE) & ~inst_mem_read_i;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        unique case (state_q)
            IDLE: begin
                if (inst_mem_read_i) begin
                    addr_d = inst_mem_address_i;
                    cnt_d  = LAT_M1;
                    if (READ_LATENCY == 1) begin
                        state_d = DONE;
                        data_d  = mem_q[rd_blk];
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                if (!inst_mem_read_i) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d = DONE;
                        data_d  = mem_q[rd_blk];
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 6'd0;
            data_q  <= 128'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    // Array contents survive reset; only the addressed lane is written.
    always_ff @(posedge clk_i) begin
        if (!reset_i && load_en_i && load_ready_o) begin
            mem_q[load_addr_i[7:2]][lane_base +: 32] <= load_data_i;
        end
    end

endmodule

// File: tb/tb_inst_memory_responder.sv
// Bench for inst_memory_responder: directed scenarios plus a randomized run, checked against
// a cycle-age reference model; a second instance covers the single-cycle latency build.
module tb_inst_memory_responder;

    localparam int L = 4;
    localparam logic [127:0] BLK5 = 128'h11111111_22222222_33333333_44444444;
    localparam logic [127:0] BLK3 = 128'hA0A0A0A0_A1A1A1A1_A2A2A2A2_A3A3A3A3;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         read = 1'b0;
    logic [5:0]   addr = 6'd0;
    logic         load_en = 1'b0;
    logic [7:0]   load_addr = 8'd0;
    logic [31:0]  load_data = 32'd0;
    logic [127:0] data;
    logic         busy, lready;

    logic         read1 = 1'b0;
    logic [5:0]   addr1 = 6'd0;
    logic         load_en1 = 1'b0;
    logic [127:0] data1;
    logic         busy1, lready1;

    int total = 0;
    int bad = 0;

    // Reference model: age counts edges since the accept edge; age == L is the delivery cycle.
    logic [31:0]  mem_m [64][4];
    logic         m_active = 1'b0;
    int           m_age = 0;
    logic [5:0]   m_addr = 6'd0;
    logic [127:0] m_data = 128'h0;

    always #5 clk = ~clk;

    inst_memory_responder #(.READ_LATENCY(L)) dut (
        .clk_i(clk), .reset_i(reset),
        .inst_mem_read_i(read), .inst_mem_address_i(addr),
        .inst_mem_data_o(data), .inst_mem_busywait_o(busy),
        .load_en_i(load_en), .load_addr_i(load_addr), .load_data_i(load_data),
        .load_ready_o(lready)
    );

    inst_memory_responder #(.READ_LATENCY(1)) dut1 (
        .clk_i(clk), .reset_i(reset),
        .inst_mem_read_i(read1), .inst_mem_address_i(addr1),
        .inst_mem_data_o(data1), .inst_mem_busywait_o(busy1),
        .load_en_i(load_en1), .load_addr_i(load_addr), .load_data_i(load_data),
        .load_ready_o(lready1)
    );

    function automatic logic [127:0] blk(input logic [5:0] a);
        return {mem_m[a][0], mem_m[a][1], mem_m[a][2], mem_m[a][3]};
    endfunction

    function automatic logic exp_busy();
        return read && !(m_active && m_age == L);
    endfunction

    function automatic logic exp_lready();
        return !read && !m_active;
    endfunction

    // Advance the model with the inputs present at the coming edge, then move past the edge.
    task automatic tick();
        logic lr;
        lr = exp_lready();
        if (reset) begin
            m_active = 1'b0;
            m_data   = 128'h0;
            m_addr   = 6'd0;
        end else begin
            if (load_en && lr) mem_m[load_addr[7:2]][load_addr[1:0]] = load_data;
            if (m_active) begin
                if (m_age == L || !read) begin
                    m_active = 1'b0;
                end else begin
                    m_age = m_age + 1;
                    if (m_age == L) m_data = blk(m_addr);
                end
            end else if (read) begin
                m_active = 1'b1;
                m_age    = 1;
                m_addr   = addr;
                if (L == 1) m_data = blk(addr);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [7:0] a, input logic [31:0] d);
        load_en = 1'b1; load_addr = a; load_data = d;
        tick();
        load_en = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; read = 1'b0; read1 = 1'b0;
        tick(); tick();
        reset = 1'b0;
        #1;
        total++; if (data !== 128'h0) begin bad++; $display("FAIL reset_data got=%h want=0", data); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (lready !== 1'b1) begin bad++; $display("FAIL reset_lready got=%b want=1", lready); end
        total++; if (data1 !== 128'h0) begin bad++; $display("FAIL reset_data1 got=%h want=0", data1); end
        tick();
    endtask

    task automatic test_fetch();
        for (int i = 0; i < 256; i++) load_word(8'(i), $urandom());
        for (int i = 0; i < 4; i++) load_word({6'd5, 2'(i)}, 32'h11111111 * (i + 1));
        total++; if (blk(6'd5) !== BLK5) begin bad++; $display("FAIL model_blk5 got=%h want=%h", blk(6'd5), BLK5); end
        read = 1'b1; addr = 6'd5;
        for (int k = 0; k <= 5; k++) begin
            if (k == 5) read = 1'b0;
            #1;
            total++;
            if (busy !== (k < 4)) begin bad++; $display("FAIL fetch_busy c%0d got=%b want=%b", k, busy, (k < 4)); end
            if (k < 4) begin
                total++; if (data !== 128'h0) begin bad++; $display("FAIL fetch_data_hold c%0d got=%h want=0", k, data); end
            end
            if (k == 4) begin
                total++; if (data !== BLK5) begin bad++; $display("FAIL fetch_data got=%h want=%h", data, BLK5); end
            end
            if (k == 5) begin
                total++; if (lready !== 1'b1) begin bad++; $display("FAIL fetch_idle_lready got=%b want=1", lready); end
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        read = 1'b1; addr = 6'd5;
        for (int k = 0; k <= 10; k++) begin
            if (k == 1) addr = 6'd6;
            if (k == 10) read = 1'b0;
            #1;
            total++;
            if (busy !== (k != 4 && k != 9 && k != 10)) begin
                bad++; $display("FAIL b2b_busy c%0d got=%b want=%b", k, busy, (k != 4 && k != 9 && k != 10));
            end
            if (k == 4) begin
                total++; if (data !== BLK5) begin bad++; $display("FAIL b2b_first got=%h want=%h", data, BLK5); end
            end
            if (k == 9) begin
                total++; if (data !== blk(6'd6)) begin bad++; $display("FAIL b2b_second got=%h want=%h", data, blk(6'd6)); end
            end
            tick();
        end
    endtask

    task automatic test_abort();
        logic [127:0] prev;
        prev = m_data;
        addr = 6'd7;
        for (int k = 0; k <= 10; k++) begin
            read = (k < 2) || (k >= 5 && k <= 9);
            #1;
            if (k == 2) begin
                total++; if (lready !== 1'b0) begin bad++; $display("FAIL abort_lready_busy got=%b want=0", lready); end
            end
            if (k == 3) begin
                total++; if (lready !== 1'b1) begin bad++; $display("FAIL abort_idle got=%b want=1", lready); end
                total++; if (data !== prev) begin bad++; $display("FAIL abort_data_kept got=%h want=%h", data, prev); end
            end
            if (k >= 5 && k <= 9) begin
                total++;
                if (busy !== (k != 9)) begin bad++; $display("FAIL abort_restart_busy c%0d got=%b want=%b", k, busy, (k != 9)); end
            end
            if (k == 9) begin
                total++; if (data !== blk(6'd7)) begin bad++; $display("FAIL abort_restart_data got=%h want=%h", data, blk(6'd7)); end
            end
            tick();
        end
    endtask

    task automatic test_addr_change_and_blocked_load();
        read = 1'b1; addr = 6'd5;
        for (int k = 0; k <= 5; k++) begin
            load_en = 1'b0;
            if (k == 1) begin
                addr = 6'd9;
                load_en = 1'b1; load_addr = {6'd5, 2'd0}; load_data = 32'hDEADBEEF;
            end
            if (k == 5) read = 1'b0;
            #1;
            if (k == 1) begin
                total++; if (lready !== 1'b0) begin bad++; $display("FAIL busy_load_lready got=%b want=0", lready); end
            end
            if (k == 4) begin
                total++; if (data !== BLK5) begin bad++; $display("FAIL addr_change_data got=%h want=%h", data, BLK5); end
            end
            tick();
        end
        load_en = 1'b0;
        read = 1'b1; addr = 6'd5;
        for (int k = 0; k < 4; k++) tick();
        #1;
        total++; if (data !== BLK5) begin bad++; $display("FAIL blocked_load_array got=%h want=%h", data, BLK5); end
        read = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_fetch();
        read = 1'b1; addr = 6'd6;
        tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0; read = 1'b0;
        #1;
        total++; if (data !== 128'h0) begin bad++; $display("FAIL midreset_data got=%h want=0", data); end
        total++; if (lready !== 1'b1) begin bad++; $display("FAIL midreset_idle got=%b want=1", lready); end
        tick();
        read = 1'b1; addr = 6'd5;
        for (int k = 0; k < 4; k++) tick();
        #1;
        total++; if (data !== BLK5) begin bad++; $display("FAIL midreset_array got=%h want=%h", data, BLK5); end
        read = 1'b0;
        tick();
    endtask

    task automatic test_latency1();
        for (int i = 0; i < 4; i++) begin
            load_en1 = 1'b1; load_addr = {6'd3, 2'(i)}; load_data = {4{8'hA0 + 8'(i)}};
            tick();
        end
        load_en1 = 1'b0;
        read1 = 1'b1; addr1 = 6'd3;
        #1;
        total++; if (busy1 !== 1'b1) begin bad++; $display("FAIL lat1_c0_busy got=%b want=1", busy1); end
        total++; if (data1 !== 128'h0) begin bad++; $display("FAIL lat1_c0_data got=%h want=0", data1); end
        tick();
        total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL lat1_c1_busy got=%b want=0", busy1); end
        total++; if (data1 !== BLK3) begin bad++; $display("FAIL lat1_c1_data got=%h want=%h", data1, BLK3); end
        tick();
        total++; if (busy1 !== 1'b1) begin bad++; $display("FAIL lat1_b2b_busy got=%b want=1", busy1); end
        tick();
        total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL lat1_b2b_done got=%b want=0", busy1); end
        read1 = 1'b0;
        tick();
        total++; if (lready1 !== 1'b1) begin bad++; $display("FAIL lat1_idle got=%b want=1", lready1); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            if (read) read = ($urandom_range(0, 99) >= 15);
            else      read = ($urandom_range(0, 99) < 50);
            addr      = 6'($urandom());
            load_en   = ($urandom_range(0, 99) < 30);
            load_addr = 8'($urandom());
            load_data = $urandom();
            reset     = ($urandom_range(0, 99) < 2);
            #1;
            total++;
            if (busy !== exp_busy() || lready !== exp_lready() || data !== m_data) begin
                bad++;
                $display("FAIL random n=%0d got busy=%b lready=%b data=%h want busy=%b lready=%b data=%h",
                         n, busy, lready, data, exp_busy(), exp_lready(), m_data);
            end
            tick();
        end
        reset = 1'b0; read = 1'b0; load_en = 1'b0;
        tick();
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_fetch();
        test_back_to_back();
        test_abort();
        test_addr_change_and_blocked_load();
        test_reset_mid_fetch();
        test_latency1();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
